// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the TDM bit scheduler that feeds the 1-to-4
// active-low demultiplexer.
//   tdm_state_t : scheduler FSM state (IDLE, SEND, GAP)
//   NUM_CH/CH_W : channel count and channel-select width
//   IDLE_*      : demux drive values while no slot is being emitted
//   bi_width()  : bit-index counter width for a given word width
// ---------------------------------------------------------------------------
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tdm_state_t;

    // With sel=0, d=1 and e=0 every demux output sits at its inactive level.
    localparam logic [CH_W-1:0] IDLE_SEL = '0;
    localparam logic            IDLE_D   = 1'b1;
    localparam logic            IDLE_E   = 1'b0;

    // A 1-bit word still needs a 1-bit index register.
    function automatic int bi_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Walks the slot position of a frame: channel ch counts 0..3 every slot and
// bit index bi counts down from WIDTH-1 each time ch wraps 3->0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear to the first slot (ch=0, bi=WIDTH-1)
//   adv         : advance to the next slot
//   nxt_ch      : channel of the position held after this edge
//   nxt_bi      : bit index of the position held after this edge
//   last_slot   : current position is the final slot (bi=0, ch=3)
// The "next" values are exported because the scheduler registers its outputs
// from the position the counter is about to take.
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BI_W  = bi_width(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            adv,
    output logic [CH_W-1:0] nxt_ch,
    output logic [BI_W-1:0] nxt_bi,
    output logic            last_slot
);

    localparam logic [BI_W-1:0] BI_TOP  = BI_W'(WIDTH - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] ch;
    logic [BI_W-1:0] bi;

    always_comb begin
        nxt_ch = ch;
        nxt_bi = bi;
        if (clr) begin
            nxt_ch = '0;
            nxt_bi = BI_TOP;
        end else if (adv) begin
            nxt_ch = ch + 2'd1;
            if (ch == CH_LAST) begin
                nxt_bi = bi - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch <= '0;
            bi <= BI_TOP;
        end else begin
            ch <= nxt_ch;
            bi <= nxt_bi;
        end
    end

    assign last_slot = (bi == '0) && (ch == CH_LAST);

endmodule

// File: rtl/tdm_bit_scheduler.sv
// ---------------------------------------------------------------------------
// tdm_bit_scheduler
// Accepts one frame of four WIDTH-bit channel words and emits it one bit per
// clock, interleaved ch0..ch3 from MSB down to LSB, on the demux inputs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : frame offered on in_data/in_mask
//   in_ready    : frame accepted this cycle when in_valid is also high
//   in_data     : ch k word = in_data[k*WIDTH +: WIDTH]
//   in_mask     : per-channel enable for the frame
//   sel_a       : demux channel select
//   dout_d      : demux serial data (1 in masked or idle slots)
//   en_e        : demux enable, active high
//   frame_done  : high during the last slot of a frame
//   busy        : high in SEND or GAP
//   dbg_state   : current FSM state
// Handshake: a frame transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is a function of state and slot position only, and
// the offered frame may change freely while in_ready is low.
// ---------------------------------------------------------------------------
module tdm_bit_scheduler
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_mask,
    output logic [CH_W-1:0]         sel_a,
    output logic                    dout_d,
    output logic                    en_e,
    output logic                    frame_done,
    output logic                    busy,
    output tdm_state_t              dbg_state
);

    localparam int BI_W = bi_width(WIDTH);

    tdm_state_t        state;
    logic [WIDTH-1:0]  shadow_word [NUM_CH];
    logic [NUM_CH-1:0] shadow_mask;
    logic [3:0]        gap_cnt;

    logic              handshake;
    logic              slot_load;
    logic              last_slot;
    logic [CH_W-1:0]   nxt_ch;
    logic [BI_W-1:0]   nxt_bi;
    logic              nxt_bit;
    logic              nxt_en;
    logic              nxt_last;

    // With no gap the last slot doubles as an accept cycle so frames abut.
    assign in_ready  = (state == IDLE) ||
                       ((state == SEND) && last_slot && (GAP == 0));
    assign handshake = in_valid && in_ready;
    // A slot is registered either for a freshly accepted frame or for the
    // next position of the frame in flight.
    assign slot_load = handshake || ((state == SEND) && !last_slot);
    assign busy      = (state == SEND) || (state == tdm_pkg::GAP);
    assign dbg_state = state;

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .BI_W  (BI_W)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (handshake),
        .adv       ((state == SEND) && !last_slot),
        .nxt_ch    (nxt_ch),
        .nxt_bi    (nxt_bi),
        .last_slot (last_slot)
    );

    // The first slot of a new frame comes straight from the input bus because
    // the shadow registers are only written on this same edge.
    always_comb begin
        nxt_bit = shadow_word[nxt_ch][nxt_bi];
        nxt_en  = shadow_mask[nxt_ch];
        if (handshake) begin
            nxt_bit = in_data[WIDTH-1];
            nxt_en  = in_mask[0];
        end
        nxt_last = (nxt_ch == CH_W'(NUM_CH - 1)) && (nxt_bi == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_a       <= IDLE_SEL;
            dout_d      <= IDLE_D;
            en_e        <= IDLE_E;
            frame_done  <= 1'b0;
            gap_cnt     <= '0;
            shadow_mask <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_word[k] <= '0;
            end
        end else begin
            if (handshake) begin
                shadow_mask <= in_mask;
                for (int k = 0; k < NUM_CH; k++) begin
                    shadow_word[k] <= in_data[k*WIDTH +: WIDTH];
                end
            end

            if (slot_load) begin
                sel_a      <= nxt_ch;
                dout_d     <= nxt_en ? nxt_bit : IDLE_D;
                en_e       <= nxt_en;
                frame_done <= nxt_last;
            end else begin
                sel_a      <= IDLE_SEL;
                dout_d     <= IDLE_D;
                en_e       <= IDLE_E;
                frame_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (last_slot && !handshake) begin
                        if (GAP > 0) begin
                            state   <= tdm_pkg::GAP;
                            gap_cnt <= 4'(GAP - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                tdm_pkg::GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_bit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tdm_bit_scheduler
// Three schedulers share one clock: (WIDTH=8,GAP=0), (WIDTH=8,GAP=3) and
// (WIDTH=1,GAP=2). The reference model turns every accepted frame into the
// list of per-cycle demux values it must produce, straight from the frame
// order rules, and compares each cycle against the head of that list.
// ---------------------------------------------------------------------------
module tb_tdm_bit_scheduler;
    import tdm_pkg::*;

    localparam int NI = 3;
    localparam int W_OF [NI] = '{8, 8, 1};
    localparam int G_OF [NI] = '{0, 3, 2};

    typedef struct packed {
        logic [1:0] sel;
        logic       d;
        logic       e;
        logic       fd;
        logic       busy;
        logic       rdy;
    } slot_t;

    localparam slot_t IDLE_ENTRY = '{sel: 2'd0, d: 1'b1, e: 1'b0, fd: 1'b0,
                                     busy: 1'b0, rdy: 1'b1};

    logic         clk;
    logic         rst_n;
    logic         in_valid [NI];
    logic [127:0] tb_data  [NI];
    logic [3:0]   tb_mask  [NI];
    logic [1:0]   sel      [NI];
    logic         dout     [NI];
    logic         en       [NI];
    logic         fd       [NI];
    logic         busy     [NI];
    logic         rdy      [NI];
    tdm_state_t   dbg      [NI];

    logic         drv_valid [NI];
    logic [127:0] drv_data  [NI];
    logic [3:0]   drv_mask  [NI];
    logic         acc       [NI];

    slot_t exp_q [NI][$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    tdm_bit_scheduler #(.WIDTH(8), .GAP(0)) u_w8g0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
        .in_data(tb_data[0][31:0]), .in_mask(tb_mask[0]), .sel_a(sel[0]),
        .dout_d(dout[0]), .en_e(en[0]), .frame_done(fd[0]), .busy(busy[0]),
        .dbg_state(dbg[0]));

    tdm_bit_scheduler #(.WIDTH(8), .GAP(3)) u_w8g3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
        .in_data(tb_data[1][31:0]), .in_mask(tb_mask[1]), .sel_a(sel[1]),
        .dout_d(dout[1]), .en_e(en[1]), .frame_done(fd[1]), .busy(busy[1]),
        .dbg_state(dbg[1]));

    tdm_bit_scheduler #(.WIDTH(1), .GAP(2)) u_w1g2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]),
        .in_data(tb_data[2][3:0]), .in_mask(tb_mask[2]), .sel_a(sel[2]),
        .dout_d(dout[2]), .en_e(en[2]), .frame_done(fd[2]), .busy(busy[2]),
        .dbg_state(dbg[2]));

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame = for bit b from MSB to LSB, for channel k 0..3: one slot.
    task automatic push_frame(input int i, input logic [127:0] data,
                              input logic [3:0] mask);
        slot_t s;
        for (int b = W_OF[i] - 1; b >= 0; b--) begin
            for (int k = 0; k < 4; k++) begin
                s.sel  = k[1:0];
                s.e    = mask[k];
                s.d    = mask[k] ? data[k*W_OF[i] + b] : 1'b1;
                s.fd   = (b == 0) && (k == 3);
                s.busy = 1'b1;
                s.rdy  = s.fd && (G_OF[i] == 0);
                exp_q[i].push_back(s);
            end
        end
        for (int g = 0; g < G_OF[i]; g++) begin
            s      = IDLE_ENTRY;
            s.busy = 1'b1;
            s.rdy  = 1'b0;
            exp_q[i].push_back(s);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge: checks this cycle's outputs, then
    // drives this cycle's inputs and records model-side acceptance.
    task automatic step();
        slot_t e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            e = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : IDLE_ENTRY;
            check_eq($sformatf("i%0d_sel", i),   sel[i],  e.sel);
            check_eq($sformatf("i%0d_dout", i),  dout[i], e.d);
            check_eq($sformatf("i%0d_en", i),    en[i],   e.e);
            check_eq($sformatf("i%0d_done", i),  fd[i],   e.fd);
            check_eq($sformatf("i%0d_busy", i),  busy[i], e.busy);
            check_eq($sformatf("i%0d_ready", i), rdy[i],  e.rdy);
            in_valid[i] = drv_valid[i];
            tb_data[i]  = drv_data[i];
            tb_mask[i]  = drv_mask[i];
            acc[i]      = drv_valid[i] && e.rdy;
            if (acc[i]) push_frame(i, drv_data[i], drv_mask[i]);
        end
    endtask

    task automatic randomize_drive();
        for (int i = 0; i < NI; i++) begin
            drv_valid[i] = ($urandom_range(0, 2) != 0);
            drv_data[i]  = {$urandom, $urandom, $urandom, $urandom};
            drv_mask[i]  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_idle_now(input string tag);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("%s_i%0d_sel", tag, i),   sel[i],  0);
            check_eq($sformatf("%s_i%0d_dout", tag, i),  dout[i], 1);
            check_eq($sformatf("%s_i%0d_en", tag, i),    en[i],   0);
            check_eq($sformatf("%s_i%0d_done", tag, i),  fd[i],   0);
            check_eq($sformatf("%s_i%0d_busy", tag, i),  busy[i], 0);
            check_eq($sformatf("%s_i%0d_state", tag, i), dbg[i],  IDLE);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t1, t2, busy_n, t_fd1, t_fd2, t_acc1, t_acc2;
        logic exp_d [4];
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; tb_data[i] = '0; tb_mask[i] = '0;
            drv_valid[i] = 1'b0; drv_data[i] = '0; drv_mask[i] = '0; acc[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_idle_now("rst");
        #1 rst_n = 1'b1;

        // Frame {F0,0F,AA,55} on WIDTH=8/GAP=0, second frame back-to-back.
        drv_valid[0] = 1'b1; drv_data[0] = 128'hF00FAA55; drv_mask[0] = 4'hF;
        t1 = -1;
        for (int n = 0; n < 10 && t1 < 0; n++) begin
            step();
            if (acc[0]) t1 = cyc;
        end
        check_eq("hs1_seen", (t1 >= 0), 1);
        drv_mask[0] = 4'b0101;
        busy_n = 0;
        for (int k = 0; k < 4; k++) begin
            drv_data[0] = {96'h0, $urandom};
            step();
            busy_n += int'(busy[0]);
            check_eq($sformatf("f1_sel%0d", k), sel[0], k);
            check_eq($sformatf("f1_dout%0d", k), dout[0], exp_d[k]);
            check_eq($sformatf("f1_rdy%0d", k), rdy[0], 0);
        end
        t2 = -1;
        for (int n = 0; n < 40 && t2 < 0; n++) begin
            drv_data[0] = {96'h0, $urandom};
            step();
            busy_n += int'(busy[0]);
            if (acc[0]) begin
                t2 = cyc;
                check_eq("f1_done_at_hs2", fd[0], 1);
            end
        end
        check_eq("b2b_spacing", t2 - t1, 32);
        drv_valid[0] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            busy_n += int'(busy[0]);
            if (busy[0] && (sel[0] == 2'd1 || sel[0] == 2'd3)) begin
                check_eq("mask_off_en", en[0], 0);
                check_eq("mask_off_d", dout[0], 1);
            end else if (busy[0]) begin
                check_eq("mask_on_en", en[0], 1);
            end
        end
        check_eq("b2b_busy_cycles", busy_n, 64);

        // GAP=3 ready timing and WIDTH=1 frame length.
        drv_valid[1] = 1'b1; drv_data[1] = {96'h0, $urandom}; drv_mask[1] = 4'hF;
        drv_valid[2] = 1'b1; drv_data[2] = {124'h0, 4'($urandom)}; drv_mask[2] = 4'hF;
        t_acc1 = -1; t_acc2 = -1; t_fd1 = -1; t_fd2 = -1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (acc[1] && t_acc1 < 0) begin t_acc1 = cyc; drv_valid[1] = 1'b0; end
            if (acc[2] && t_acc2 < 0) begin t_acc2 = cyc; drv_valid[2] = 1'b0; end
            if (fd[1] && t_fd1 < 0) t_fd1 = cyc;
            if (fd[2] && t_fd2 < 0) t_fd2 = cyc;
            if (t_fd1 >= 0 && cyc > t_fd1 && cyc <= t_fd1 + 3) begin
                check_eq("gap_not_ready", rdy[1], 0);
                check_eq("gap_idle_en", en[1], 0);
            end
            if (t_fd1 >= 0 && cyc == t_fd1 + 4) check_eq("gap_then_ready", rdy[1], 1);
        end
        check_eq("g3_frame_len", t_fd1 - t_acc1, 32);
        check_eq("w1_frame_len", t_fd2 - t_acc2, 4);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            randomize_drive();
            step();
        end

        // Reset in the middle of a frame on instance 0.
        drv_valid[0] = 1'b1;
        t1 = -1;
        for (int n = 0; n < 200 && t1 < 0; n++) begin
            step();
            if (busy[0] && exp_q[0].size() > 8) t1 = cyc;
        end
        check_eq("midframe_reached", (t1 >= 0), 1);
        #2 rst_n = 1'b0;
        #1 check_idle_now("async_rst");
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            drv_valid[i] = 1'b0;
            in_valid[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_idle_now("rst_hold");
        #1 rst_n = 1'b1;
        for (int i = 0; i < NI; i++) check_eq($sformatf("post_rst_ready_i%0d", i), rdy[i], 1);

        for (int n = 0; n < 300; n++) begin
            randomize_drive();
            step();
        end
        for (int i = 0; i < NI; i++) drv_valid[i] = 1'b0;
        for (int n = 0; n < 80; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
